// File: rtl/muldiv_pkg.sv
// Shared types and sizing helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    // Operation encoding as presented by the datapath
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    // Control FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Default operand width (MIPS word)
    localparam int MD_WIDTH = 32;

    // Step counter width: must hold values up to WIDTH
    function automatic int muldiv_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/muldiv_twos_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and
// for restoring the sign of products, quotients and remainders.
module twos_neg #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO register pair.
// Operands are reduced to magnitudes on acceptance, one bit is processed
// per RUN cycle, and signs are reapplied in the FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = muldiv_cnt_w(WIDTH);

    state_t             state_reg, state_next;
    muldiv_op_t         op_reg;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic               sign_a_reg, sign_b_reg, dz_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg, dbz_reg;

    muldiv_op_t         op_in;
    logic               is_signed_in, is_div_reg;
    logic [WIDTH-1:0]   opnd_in  [2];
    logic [WIDTH-1:0]   opnd_abs [2];

    assign op_in        = muldiv_op_t'(op);
    assign is_signed_in = (op_in == MD_MULT) || (op_in == MD_DIV);
    assign is_div_reg   = (op_reg == MD_DIV) || (op_reg == MD_DIVU);
    assign opnd_in[0]   = a;
    assign opnd_in[1]   = b;

    // Magnitude of each incoming operand (raw value for unsigned ops)
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            twos_neg #(.WIDTH(WIDTH)) u_abs (
                .neg  (is_signed_in & opnd_in[gi][WIDTH-1]),
                .din  (opnd_in[gi]),
                .dout (opnd_abs[gi])
            );
        end
    endgenerate

    // One multiply step: add multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the accumulator right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (b_reg[0] ? {1'b0, a_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // One restoring-divide step: remainder lives in the upper half,
    // quotient bits shift into the lower half. With a zero divisor the
    // remainder ends up holding the dividend magnitude.
    logic [WIDTH:0]     div_shift, div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], a_reg[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_reg};
    assign div_rem   = div_ge ? (div_shift - {1'b0, b_reg}) : div_shift;
    assign div_next  = {div_rem[WIDTH-1:0], acc_reg[WIDTH-2:0], div_ge};

    // Sign restoration of the finished results
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    twos_neg #(.WIDTH(2*WIDTH)) u_neg_prod (
        .neg  (sign_a_reg ^ sign_b_reg),
        .din  (acc_reg),
        .dout (prod_fix)
    );

    twos_neg #(.WIDTH(WIDTH)) u_neg_quo (
        .neg  (sign_a_reg ^ sign_b_reg),
        .din  (acc_reg[WIDTH-1:0]),
        .dout (quo_fix)
    );

    twos_neg #(.WIDTH(WIDTH)) u_neg_rem (
        .neg  (sign_a_reg),
        .din  (acc_reg[2*WIDTH-1:WIDTH]),
        .dout (rem_fix)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state and busy decode
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = S_FIX;
            end
            S_FIX: begin
                busy       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, iterative step datapath and HI/LO updates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_reg     <= MD_MULT;
            a_reg      <= '0;
            b_reg      <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            dz_reg     <= 1'b0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_reg     <= op_in;
                        a_reg      <= opnd_abs[0];
                        b_reg      <= opnd_abs[1];
                        sign_a_reg <= is_signed_in & a[WIDTH-1];
                        sign_b_reg <= is_signed_in & b[WIDTH-1];
                        dz_reg     <= (b == '0);
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                    end else begin
                        if (hi_we) hi_reg <= wdata;
                        if (lo_we) lo_reg <= wdata;
                    end
                end
                S_RUN: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (is_div_reg) begin
                        acc_reg <= div_next;
                        a_reg   <= a_reg << 1;
                    end else begin
                        acc_reg <= mul_next;
                        b_reg   <= b_reg >> 1;
                    end
                end
                S_FIX: begin
                    if (is_div_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= dz_reg ? '1 : quo_fix;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion pulse and divide-by-zero flag, one cycle after FIX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
        end else begin
            done_reg <= (state_reg == S_FIX);
            dbz_reg  <= (state_reg == S_FIX) && is_div_reg && dz_reg;
        end
    end

    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table applied back-to-back
// through a scoreboard, plus hand sequences for register writes, request
// conflicts during RUN and asynchronous reset mid-operation.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0, wdata = '0;
    logic         hi_we = 1'b0, lo_we = 1'b0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t         sb[$];
    vec_t         table_v[13];
    int           n_checks = 0;
    int           n_fail = 0;
    int           n_txn = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
        vec_t v;
        v.op = o; v.a = aa; v.b = bb; v.hi = eh; v.lo = el; v.dbz = ed;
        return v;
    endfunction

    // Reference arithmetic from 64-bit integer operations
    function automatic vec_t model(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        vec_t v;
        logic signed [63:0] sa, sbv, q, r;
        logic [63:0] ua, ub, p;
        v.op = o; v.a = aa; v.b = bb; v.dbz = 1'b0; v.hi = '0; v.lo = '0;
        sa  = {{32{aa[31]}}, aa};
        sbv = {{32{bb[31]}}, bb};
        ua  = {32'b0, aa};
        ub  = {32'b0, bb};
        if (o == 2'b00) begin
            p = sa * sbv;
            v.hi = p[63:32]; v.lo = p[31:0];
        end else if (o == 2'b01) begin
            p = ua * ub;
            v.hi = p[63:32]; v.lo = p[31:0];
        end else if (bb == '0) begin
            v.hi = aa; v.lo = '1; v.dbz = 1'b1;
        end else if (o == 2'b10) begin
            q = sa / sbv; r = sa % sbv;
            v.lo = q[31:0]; v.hi = r[31:0];
        end else begin
            p = ua / ub; v.lo = p[31:0];
            p = ua % ub; v.hi = p[31:0];
        end
        return v;
    endfunction

    // Drive a request at a falling edge and record its expected result
    task automatic issue(input vec_t v);
        sb.push_back(v);
        op = v.op; a = v.a; b = v.b; start = 1'b1;
    endtask

    // Follow one operation to its done pulse; optionally inject a
    // start + MTHI/MTLO request at busy cycle 'inject'.
    task automatic wait_done(input int inject);
        int   cnt = 0;
        bit   got = 1'b0;
        vec_t e;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) cnt++;
                chk("dbz_without_done", {31'b0, div_by_zero}, '0);
                chk("hi_hold", hi, m_hi);
                chk("lo_hold", lo, m_lo);
                if (cnt == inject) begin
                    start = 1'b1; op = 2'b11; a = 32'h1111; b = 32'h3;
                    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
                end
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got no done after %0d busy cycles, required done at 33", cnt);
            return;
        end
        chk("busy_cycles", cnt, 33);
        chk("busy_at_done", {31'b0, busy}, '0);
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard: got done with empty queue, required no done");
            return;
        end
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
        m_hi = e.hi; m_lo = e.lo;
        n_txn++;
        $display("txn %0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d busy_cycles=%0d",
                 n_txn, e.op, e.a, e.b, hi, lo, div_by_zero, cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        table_v[0]  = mk(2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        table_v[1]  = mk(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        table_v[2]  = mk(2'b01, 32'h00009504, 32'h00000002, 32'h00000000, 32'h00012A08, 1'b0);
        table_v[3]  = mk(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        table_v[4]  = mk(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        table_v[5]  = mk(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        table_v[6]  = mk(2'b10, 32'h00009504, 32'h00000000, 32'h00009504, 32'hFFFFFFFF, 1'b1);
        table_v[7]  = mk(2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
        table_v[8]  = mk(2'b11, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        table_v[9]  = mk(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        table_v[10] = mk(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        table_v[11] = mk(2'b01, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0);
        table_v[12] = mk(2'b11, 32'd5,        32'd9,        32'd5,        32'd0,        1'b0);

        // Reset state, held and after release
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, '0);
        chk("rst_done", {31'b0, done}, '0);
        chk("rst_dbz", {31'b0, div_by_zero}, '0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, '0);

        // MTHI alone, then MTHI+MTLO together
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo", lo, '0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55AA;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("both_hi", hi, 32'h55AA);
        chk("both_lo", lo, 32'h55AA);
        m_hi = 32'h55AA; m_lo = 32'h55AA;

        // start and MTLO in the same idle cycle: the write is dropped
        lo_we = 1'b1; wdata = 32'hFFFF;
        issue(mk(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0));
        wait_done(-1);

        // Vector table, each request issued in the previous done cycle
        for (int i = 0; i < 13; i++) begin
            issue(table_v[i]);
            wait_done(-1);
        end

        // start + MTHI/MTLO during RUN are ignored
        issue(mk(2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0));
        wait_done(10);
        @(negedge clk);
        chk("no_queued_op_busy", {31'b0, busy}, '0);

        // Random operations against the integer model
        for (int i = 0; i < 8; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 5) ? 32'h0 : $urandom >> $urandom_range(0, 28);
            issue(model(ro, ra, rb));
            wait_done(-1);
        end

        // Asynchronous reset in the middle of RUN aborts the operation
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("pre_abort_hi", hi, 32'hDEADBEEF);
        issue(mk(2'b00, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0));
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, '0);
        chk("abort_done", {31'b0, done}, '0);
        chk("abort_hi", hi, '0);
        chk("abort_lo", lo, '0);
        void'(sb.pop_back());
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_abort_busy", {31'b0, busy}, '0);
        chk("post_abort_done", {31'b0, done}, '0);
        issue(mk(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0));
        wait_done(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
